freq_scan: RTL and testbench

- Measurement end of the design-select interface: drives the mux select code and counts rising edges of the returned wave over a fixed gate window.
- Supports a single-design measurement or a sweep across all NDESIGNS Superchip outputs.
- Sits between the host command/result path and the input mux; each result is returned through a valid/ready handshake.

---
 rtl/freq_scan_pkg.sv | 21 ++
 rtl/freq_scan_edge_sync.sv | 28 ++
 rtl/freq_scan.sv | 169 ++++++++++++++++
 tb/tb_freq_scan.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_scan_pkg.sv
// Shared types and defaults for the frequency-scan measurement block.
package freq_scan_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    // 1 ms gate at 50 MHz.
    localparam int DEFAULT_GATE_CYCLES   = 50000;
    // Must stay >= 4 so the synchronizer flushes the previous design's wave.
    localparam int DEFAULT_SETTLE_CYCLES = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/freq_scan_edge_sync.sv
// Two-flop synchronizer for an asynchronous wave plus a rising-edge pulse.
module edge_sync (
    input  logic clk_i,
    input  logic srst_i,
    input  logic async_i,
    output logic rise_o
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Synchronize the pin and keep one cycle of history for edge detection.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= async_i;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rise_o = sync_q2 & ~prev_q;

endmodule

// File: rtl/freq_scan.sv
// Drives the design-select code and counts rising edges of the returned wave
// over a fixed gate window; single-design or full-sweep measurements.
module freq_scan
    import freq_scan_pkg::*;
#(
    parameter int NDESIGNS      = 24,
    parameter int DATA_WIDTH    = 16,
    parameter int COUNT_WIDTH   = 24,
    parameter int GATE_CYCLES   = DEFAULT_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic                   start_i,
    input  logic                   sweep_i,
    input  logic [DATA_WIDTH-1:0]  design_sel_i,
    output logic [DATA_WIDTH-1:0]  select_input_o,
    input  logic                   wave_in_i,
    output logic                   busy_o,
    output logic                   cmd_error_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [COUNT_WIDTH-1:0] result_count_o,
    output logic [DATA_WIDTH-1:0]  result_design_o,
    output logic                   result_ovf_o
);

    localparam int TW = $clog2(max_int(GATE_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [TW-1:0]          SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]          GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0]  LAST_IDX    = DATA_WIDTH'(NDESIGNS - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;

    state_e                   state_q;
    logic [TW-1:0]            timer_q;
    logic [DATA_WIDTH-1:0]    idx_q;
    logic                     sweep_q;
    logic [COUNT_WIDTH-1:0]   edge_cnt_q;
    logic [COUNT_WIDTH-1:0]   edge_cnt_d;
    logic                     ovf_q;
    logic                     ovf_d;
    logic [DATA_WIDTH-1:0]    select_q;
    logic                     busy_q;
    logic                     cmd_error_q;
    logic                     valid_q;
    logic [COUNT_WIDTH-1:0]   res_count_q;
    logic [DATA_WIDTH-1:0]    res_design_q;
    logic                     res_ovf_q;
    logic                     rise;

    edge_sync u_edge_sync (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .async_i (wave_in_i),
        .rise_o  (rise)
    );

    // Saturating edge count; an edge seen at all-ones flags overflow instead.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        if (rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Sequencer: select -> settle -> gate -> hold result until accepted.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            sweep_q      <= 1'b0;
            edge_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            select_q     <= '0;
            busy_q       <= 1'b0;
            cmd_error_q  <= 1'b0;
            valid_q      <= 1'b0;
            res_count_q  <= '0;
            res_design_q <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            cmd_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    edge_cnt_q <= '0;
                    ovf_q      <= 1'b0;
                    if (start_i) begin
                        if (sweep_i) begin
                            idx_q    <= '0;
                            select_q <= '0;
                            sweep_q  <= 1'b1;
                            timer_q  <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SETTLE;
                        end else if (design_sel_i <= LAST_IDX) begin
                            idx_q    <= design_sel_i;
                            select_q <= design_sel_i;
                            sweep_q  <= 1'b0;
                            timer_q  <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SETTLE;
                        end else begin
                            cmd_error_q <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Edges from the mux transition are thrown away here.
                    edge_cnt_q <= '0;
                    ovf_q      <= 1'b0;
                    if (timer_q == SETTLE_LAST) begin
                        timer_q <= '0;
                        state_q <= ST_GATE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_GATE: begin
                    edge_cnt_q <= edge_cnt_d;
                    ovf_q      <= ovf_d;
                    if (timer_q == GATE_LAST) begin
                        // Include an edge detected in the final gate cycle.
                        res_count_q  <= edge_cnt_d;
                        res_ovf_q    <= ovf_d;
                        res_design_q <= idx_q;
                        valid_q      <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= ST_HOLD;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (valid_q && result_ready_i) begin
                        valid_q <= 1'b0;
                        if (!sweep_q || idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q    <= idx_q + DATA_WIDTH'(1);
                            select_q <= idx_q + DATA_WIDTH'(1);
                            timer_q  <= '0;
                            state_q  <= ST_SETTLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign select_input_o  = select_q;
    assign busy_o          = busy_q;
    assign cmd_error_o     = cmd_error_q;
    assign result_valid_o  = valid_q;
    assign result_count_o  = res_count_q;
    assign result_design_o = res_design_q;
    assign result_ovf_o    = res_ovf_q;

endmodule

// File: tb/tb_freq_scan.sv
// Self-checking bench for freq_scan: randomized wave phases/periods against
// an edge-window reference model built from the recorded pin waveform.
module tb_freq_scan;

    localparam int NDES   = 24;
    localparam int DW     = 16;
    localparam int CW     = 24;
    localparam int CW2    = 4;
    localparam int GATE   = 100;
    localparam int SETTLE = 8;
    localparam int HMAX   = 16384;
    // A pin edge in cycle e is seen by the counter in cycle e+LAG.
    localparam int LAG    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          srst, start, sweep, ready, wave;
    logic [DW-1:0] dsel;
    logic [DW-1:0] select_o, design_o;
    logic          busy_o, err_o, valid_o, ovf_o;
    logic [CW-1:0] count_o;

    logic           start2, sweep2, wave2;
    logic [DW-1:0]  dsel2;
    logic [DW-1:0]  select2_o, design2_o;
    logic           busy2_o, err2_o, valid2_o, ovf2_o;
    logic [CW2-1:0] count2_o;

    int per[NDES];
    int ph[NDES];
    int ph2;
    int drv_sel;
    bit hist[HMAX];
    bit hist2[HMAX];

    int tests_run = 0;
    int tests_failed = 0;

    freq_scan #(.NDESIGNS(NDES), .DATA_WIDTH(DW), .COUNT_WIDTH(CW),
                .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) u_dut (
        .clk_i(clk), .srst_i(srst), .start_i(start), .sweep_i(sweep),
        .design_sel_i(dsel), .select_input_o(select_o), .wave_in_i(wave),
        .busy_o(busy_o), .cmd_error_o(err_o), .result_valid_o(valid_o),
        .result_ready_i(ready), .result_count_o(count_o),
        .result_design_o(design_o), .result_ovf_o(ovf_o)
    );

    freq_scan #(.NDESIGNS(NDES), .DATA_WIDTH(DW), .COUNT_WIDTH(CW2),
                .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) u_ovf (
        .clk_i(clk), .srst_i(srst), .start_i(start2), .sweep_i(sweep2),
        .design_sel_i(dsel2), .select_input_o(select2_o), .wave_in_i(wave2),
        .busy_o(busy2_o), .cmd_error_o(err2_o), .result_valid_o(valid2_o),
        .result_ready_i(ready), .result_count_o(count2_o),
        .result_design_o(design2_o), .result_ovf_o(ovf2_o)
    );

    // Mux model: each design emits its own square wave; record the pin.
    always @(negedge clk) begin
        drv_sel = int'(select_o);
        if (drv_sel < NDES) wave = ((cyc + ph[drv_sel]) % per[drv_sel]) < (per[drv_sel] / 2);
        else                wave = 1'b0;
        wave2 = ((cyc + ph2) % 4) < 2;
        if (cyc < HMAX) begin
            hist[cyc]  = wave;
            hist2[cyc] = wave2;
        end
    end

    // Rising pin edges whose detection falls inside gate cycles [first,last].
    function automatic int model_count(input int first, input int last, input bit alt);
        int n = 0;
        for (int e = first - LAG; e <= last - LAG; e++) begin
            if (e >= 1 && e < HMAX) begin
                if (alt ? (hist2[e] && !hist2[e-1]) : (hist[e] && !hist[e-1])) n++;
            end
        end
        return n;
    endfunction

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({select_o, busy_o, err_o, valid_o, count_o, design_o, ovf_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got sel=%0d busy=%0b err=%0b valid=%0b cnt=%0d des=%0d ovf=%0b, expected all 0",
                     select_o, busy_o, err_o, valid_o, count_o, design_o, ovf_o);
        end
        tests_run++;
        if ({busy2_o, valid2_o, count2_o, ovf2_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs_ovf_inst: got busy=%0b valid=%0b cnt=%0d ovf=%0b, expected 0",
                     busy2_o, valid2_o, count2_o, ovf2_o);
        end
        srst = 1'b0;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_single(input int d, input int period);
        int c, v, exp_cnt;
        bit seen;
        per[d] = period;
        ph[d]  = $urandom_range(0, period - 1);
        start = 1'b1; sweep = 1'b0; dsel = DW'(d);
        c = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (select_o !== DW'(d) || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_select: got sel=%0d busy=%0b, expected sel=%0d busy=1", select_o, busy_o, d);
        end
        seen = 1'b0;
        for (int i = 0; i < SETTLE + GATE + 20 && !seen; i++) begin
            if (valid_o) seen = 1'b1;
            else @(negedge clk);
        end
        v = cyc;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL single_timeout: got no result_valid, expected one at cycle %0d", c + SETTLE + GATE);
        end else begin
            exp_cnt = model_count(c + SETTLE, c + SETTLE + GATE - 1, 1'b0);
            if (v != c + SETTLE + GATE || count_o !== CW'(exp_cnt) || design_o !== DW'(d) || ovf_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_result: got cyc=%0d cnt=%0d des=%0d ovf=%0b, expected cyc=%0d cnt=%0d des=%0d ovf=0",
                         v, count_o, design_o, ovf_o, c + SETTLE + GATE, exp_cnt, d);
            end
        end
        @(negedge clk);
        tests_run++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got valid=%0b busy=%0b, expected 0 0", valid_o, busy_o);
        end
        $display("[TB] single design=%0d period=%0d count=%0d", d, period, count_o);
    endtask

    // Sweep; optionally stalls the consumer on design 3, then resets after design 4.
    task automatic test_sweep(input bit stall);
        int c, v, exp_cnt, last_k;
        bit seen, bad;
        last_k = stall ? 4 : NDES - 1;
        for (int k = 0; k < NDES; k++) begin
            per[k] = 2 * (k + 2);
            ph[k]  = $urandom_range(0, per[k] - 1);
        end
        ready = 1'b1;
        start = 1'b1; sweep = 1'b1; dsel = DW'($urandom_range(0, 65535));
        c = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            seen = 1'b0;
            for (int i = 0; i < SETTLE + GATE + 20 && !seen; i++) begin
                if (valid_o) seen = 1'b1;
                else @(negedge clk);
            end
            v = cyc;
            exp_cnt = model_count(c + SETTLE, c + SETTLE + GATE - 1, 1'b0);
            tests_run++;
            if (!seen) begin
                tests_failed++;
                $display("FAIL sweep_timeout: got no result for design %0d, expected one", k);
                break;
            end
            if (v != c + SETTLE + GATE || count_o !== CW'(exp_cnt) || design_o !== DW'(k)
                || ovf_o !== 1'b0 || select_o !== DW'(k)) begin
                tests_failed++;
                $display("FAIL sweep_result: got cyc=%0d cnt=%0d des=%0d sel=%0d ovf=%0b, expected cyc=%0d cnt=%0d des=%0d sel=%0d ovf=0",
                         v, count_o, design_o, select_o, ovf_o, c + SETTLE + GATE, exp_cnt, k, k);
            end
            $display("[TB] sweep design=%0d count=%0d expected=%0d", k, count_o, exp_cnt);
            if (stall && k == 3) begin
                ready = 1'b0;
                bad = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (valid_o !== 1'b1 || count_o !== CW'(exp_cnt) || design_o !== 3'd3
                        || select_o !== DW'(3) || busy_o !== 1'b1 || ovf_o !== 1'b0) bad = 1'b1;
                end
                tests_run++;
                if (bad) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got valid=%0b cnt=%0d des=%0d sel=%0d, expected stable valid=1 cnt=%0d des=3 sel=3",
                             valid_o, count_o, design_o, select_o, exp_cnt);
                end
                ready = 1'b1;
                c = cyc + 1;
            end else begin
                c = v + 1;
            end
            if (k < last_k) @(negedge clk);
        end
        if (stall) begin
            srst = 1'b1;
            @(negedge clk);
            tests_run++;
            if ({select_o, busy_o, err_o, valid_o, count_o, design_o, ovf_o} !== '0) begin
                tests_failed++;
                $display("FAIL reset_in_hold: got sel=%0d busy=%0b valid=%0b cnt=%0d, expected all 0",
                         select_o, busy_o, valid_o, count_o);
            end
            srst = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_end: got busy=%0b valid=%0b, expected 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_error(input int bad_sel);
        logic [DW-1:0] prev_sel;
        bit bad;
        prev_sel = select_o;
        start = 1'b1; sweep = 1'b0; dsel = DW'(bad_sel);
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || select_o !== prev_sel) begin
            tests_failed++;
            $display("FAIL error_pulse: got err=%0b busy=%0b sel=%0d, expected err=1 busy=0 sel=%0d",
                     err_o, busy_o, select_o, prev_sel);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0 || select_o !== prev_sel) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL error_after: got err=%0b busy=%0b valid=%0b, expected 0 0 0", err_o, busy_o, valid_o);
        end
        $display("[TB] rejected design_sel=%0d", bad_sel);
    endtask

    task automatic test_reset_midgate();
        int c;
        bit bad;
        per[7] = 10; ph[7] = $urandom_range(0, 9);
        start = 1'b1; sweep = 1'b0; dsel = DW'(7);
        c = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + SETTLE + 20) @(negedge clk);
        start = 1'b1; sweep = 1'b1; dsel = DW'(2);
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (select_o !== DW'(7) || busy_o !== 1'b1 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_in_gate: got sel=%0d busy=%0b err=%0b, expected sel=7 busy=1 err=0",
                     select_o, busy_o, err_o);
        end
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        tests_run++;
        if ({select_o, busy_o, err_o, valid_o, count_o, design_o, ovf_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_gate: got sel=%0d busy=%0b valid=%0b cnt=%0d, expected all 0",
                     select_o, busy_o, valid_o, count_o);
        end
        bad = 1'b0;
        for (int i = 0; i < SETTLE + GATE + 20; i++) begin
            @(negedge clk);
            if (valid_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL no_result_after_reset: got a result or busy, expected idle");
        end
        $display("[TB] reset mid-gate checked");
    endtask

    task automatic test_ovf();
        int c, raw, exp_cnt;
        bit seen, exp_ovf;
        ph2 = $urandom_range(0, 3);
        start2 = 1'b1; sweep2 = 1'b0; dsel2 = '0;
        c = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < SETTLE + GATE + 20 && !seen; i++) begin
            if (valid2_o) seen = 1'b1;
            else @(negedge clk);
        end
        raw     = model_count(c + SETTLE, c + SETTLE + GATE - 1, 1'b1);
        exp_cnt = (raw > 15) ? 15 : raw;
        exp_ovf = (raw > 15);
        tests_run++;
        if (!seen || count2_o !== CW2'(exp_cnt) || ovf2_o !== exp_ovf) begin
            tests_failed++;
            $display("FAIL overflow: got seen=%0b cnt=%0d ovf=%0b, expected cnt=%0d ovf=%0b",
                     seen, count2_o, ovf2_o, exp_cnt, exp_ovf);
        end
        $display("[TB] overflow raw_edges=%0d count=%0d ovf=%0b", raw, count2_o, ovf2_o);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < NDES; k++) begin
            per[k] = 10;
            ph[k]  = 0;
        end
        ph2 = 0;
        srst = 1'b1; start = 1'b0; sweep = 1'b0; ready = 1'b1; dsel = '0;
        start2 = 1'b0; sweep2 = 1'b0; dsel2 = '0;
        @(negedge clk);
        test_reset();
        test_single(5, 10);
        test_single($urandom_range(0, NDES - 1), $urandom_range(3, 16));
        test_error(NDES);
        test_error($urandom_range(NDES + 1, 65535));
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_reset_midgate();
        test_ovf();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
